// File: rtl/fifo_pack_pkg.sv
// Shared constants and helpers for the FIFO read-side word packer.
// Defaults match the standard 8-bit x4 configuration.
package fifo_pack_pkg;

    localparam int P_DSIZE   = 8;
    localparam int P_RATIO   = 4;
    localparam int P_TMO     = 16;
    localparam int MAX_RATIO = 16;

    localparam int WW = P_DSIZE * P_RATIO;
    localparam int CW = $clog2(P_RATIO);
    localparam int TW = $clog2(P_TMO + 1);

    // Sized for the widest legal RATIO; callers truncate to their own lane count.
    function automatic logic [MAX_RATIO-1:0] keep_mask(input logic [31:0] n);
        logic [MAX_RATIO-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_RATIO; i++) begin
            m[i] = (32'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Saturating idle counter that requests a flush once a partial word has been
// starved of FIFO entries for TMO consecutive cycles.
module pack_idle_timer
    import fifo_pack_pkg::*;
#(
    parameter int TMO = P_TMO
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_partial,
    input  logic i_empty,
    input  logic i_pop,
    input  logic i_clear,
    output logic o_tmo_hit
);

    localparam int LTW = $clog2(TMO + 1);

    logic [LTW-1:0] r_idle;

    // Holds at TMO until the flush it requested actually fires.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_partial || i_pop || i_clear) begin
            r_idle <= '0;
        end else if (i_empty && (r_idle != LTW'(TMO))) begin
            r_idle <= r_idle + LTW'(1);
        end
    end

    assign o_tmo_hit = (r_idle == LTW'(TMO));

endmodule

// File: rtl/fifo_rd_pack.sv
// Read-domain consumer of the async FIFO: packs RATIO entries into one wide
// word on a valid/ready stream, with flush and idle-timeout partial words.
module fifo_rd_pack
    import fifo_pack_pkg::*;
#(
    parameter int DSIZE = P_DSIZE,
    parameter int RATIO = P_RATIO,
    parameter int TMO   = P_TMO
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic [DSIZE-1:0]       rdata,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*RATIO-1:0] out_data,
    output logic [RATIO-1:0]       out_keep,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int LW  = DSIZE * RATIO;
    localparam int LCW = $clog2(RATIO);

    logic [RATIO-1:0][DSIZE-1:0] r_acc;
    logic [LCW-1:0]              r_cnt;
    logic                        r_flush_pend;
    logic                        r_out_valid;
    logic [LW-1:0]               r_out_data;
    logic [RATIO-1:0]            r_out_keep;

    logic                        w_partial;
    logic                        w_last;
    logic                        w_out_free;
    logic                        w_tmo_hit;
    logic                        w_fl_go;
    logic                        w_pop;
    logic [RATIO-1:0]            w_mask;
    logic [LW-1:0]               w_flush_data;

    assign w_partial  = (r_cnt != '0);
    assign w_last     = (r_cnt == LCW'(RATIO - 1));
    assign w_out_free = !r_out_valid || out_ready;
    assign w_fl_go    = (r_flush_pend || flush || w_tmo_hit) && w_partial && w_out_free;
    // A completing pop needs a free output slot; a flush always wins over a pop.
    assign w_pop      = !rrst && !rempty && !w_fl_go && (!w_last || w_out_free);
    assign w_mask     = RATIO'(keep_mask(32'(r_cnt)));

    always_comb begin
        w_flush_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (w_mask[i]) begin
                w_flush_data[i*DSIZE +: DSIZE] = r_acc[i];
            end
        end
    end

    generate
        if (TMO > 0) begin : g_tmo
            pack_idle_timer #(
                .TMO(TMO)
            ) u_idle_timer (
                .i_clk    (rclk),
                .i_rst    (rrst),
                .i_partial(w_partial),
                .i_empty  (rempty),
                .i_pop    (w_pop),
                .i_clear  (w_fl_go),
                .o_tmo_hit(w_tmo_hit)
            );
        end else begin : g_no_tmo
            assign w_tmo_hit = 1'b0;
        end
    endgenerate

    // Drain first; a same-cycle load below overrides the clear of out_valid.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_fl_go) begin
                r_out_data  <= w_flush_data;
                r_out_keep  <= w_mask;
                r_out_valid <= 1'b1;
                r_cnt       <= '0;
            end else if (w_pop) begin
                r_acc[r_cnt] <= rdata;
                if (w_last) begin
                    r_out_data  <= {rdata, r_acc[RATIO-2:0]};
                    r_out_keep  <= '1;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                end else begin
                    r_cnt <= r_cnt + LCW'(1);
                end
            end
            // A pending flush is meaningless once the accumulator is empty.
            if (w_fl_go || !w_partial) begin
                r_flush_pend <= 1'b0;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign rinc      = w_pop;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_valid = r_out_valid;
    assign busy      = w_partial || r_out_valid;

endmodule
